// File: rtl/axis_extremum_pkg.sv
// Shared types and helpers for the extremum averager: pair/result layouts,
// frame FSM states and the stage-1 peak-to-peak / midpoint arithmetic.
package axis_extremum_pkg;

  localparam int HW = 16;

  typedef struct packed {
    logic signed [HW-1:0] max;
    logic signed [HW-1:0] min;
  } extremum_pair_t;

  typedef struct packed {
    logic signed [HW-1:0] offset;
    logic [HW-1:0]        amplitude;
  } result_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // An inverted pair (max < min) contributes no amplitude.
  function automatic logic [HW:0] peak_to_peak(input extremum_pair_t p);
    logic [HW:0] d;
    d = {p.max[HW-1], p.max} - {p.min[HW-1], p.min};
    if (p.max < p.min) begin
      return {(HW+1){1'b0}};
    end else begin
      return d;
    end
  endfunction

  function automatic logic signed [HW:0] mid_sum(input extremum_pair_t p);
    return $signed({p.max[HW-1], p.max}) + $signed({p.min[HW-1], p.min});
  endfunction

  function automatic logic [4:0] clamp_lc(input logic [4:0] req, input logic [4:0] lim);
    if (req > lim) begin
      return lim;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/axis_extremum_averager_holder.sv
// Output register for the averager: holds a result until accepted and flags
// a pending result being replaced by a newer one.
module axis_result_holder
  import axis_extremum_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  result_t load_data,
  input  logic    ready,
  output result_t data,
  output logic    valid,
  output logic    overrun
);

  // Result register with valid/ready hold and overwrite detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      data    <= load_data;
      valid   <= 1'b1;
      overrun <= valid && !ready;
    end else begin
      overrun <= 1'b0;
      if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_extremum_averager.sv
// Averages 2^log_count {max,min} pairs into one {offset, amplitude} AXIS word.
// Optional peak-amplitude tracker enabled by defining AXIS_EXTREMUM_PEAK_HOLD_EN.
module axis_extremum_averager
  import axis_extremum_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG_COUNT    = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [4:0]                  log_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        overrun
`ifdef AXIS_EXTREMUM_PEAK_HOLD_EN
  ,
  input  logic                        clear_peak,
  output logic [HW-1:0]               peak_amplitude
`endif
);

  localparam int         ACC_W  = HW + 1 + MAX_LOG_COUNT;
  localparam logic [4:0] MAX_LC = 5'(MAX_LOG_COUNT);

  extremum_pair_t            in_pair_s;
  logic                      s_ready_r;
  logic                      s_fire_s;
  logic                      s1_valid_r;
  logic [HW:0]               s1_pp_r;
  logic signed [HW:0]        s1_mid_r;
  logic [4:0]                s1_lc_r;
  state_t                    state_r;
  logic [4:0]                lc_r;
  logic [MAX_LOG_COUNT-1:0]  count_r;
  logic [MAX_LOG_COUNT-1:0]  count_next_s;
  logic [MAX_LOG_COUNT-1:0]  last_idx_s;
  logic [ACC_W-1:0]          acc_pp_r;
  logic signed [ACC_W-1:0]   acc_mid_r;
  logic [5:0]                shift_s;
  logic [ACC_W-1:0]          amp_full_s;
  logic signed [ACC_W-1:0]   off_full_s;
  logic                      flush_s;
  result_t                   result_s;
  result_t                   hold_data_s;

  assign in_pair_s     = S_AXIS_tdata;
  assign s_fire_s      = S_AXIS_tvalid && s_ready_r;
  assign S_AXIS_tready = s_ready_r;

  // Stage 1: per-pair arithmetic, with the frame length sampled at handshake
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_ready_r  <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_pp_r    <= '0;
      s1_mid_r   <= '0;
      s1_lc_r    <= 5'd0;
    end else begin
      s_ready_r  <= 1'b1;
      s1_valid_r <= s_fire_s;
      if (s_fire_s) begin
        s1_pp_r  <= peak_to_peak(in_pair_s);
        s1_mid_r <= mid_sum(in_pair_s);
        s1_lc_r  <= clamp_lc(log_count, MAX_LC);
      end
    end
  end

  assign count_next_s = count_r + MAX_LOG_COUNT'(1);
  assign last_idx_s   = ~({MAX_LOG_COUNT{1'b1}} << lc_r);
  assign shift_s      = {1'b0, lc_r} + 6'd1;
  assign amp_full_s   = acc_pp_r >> shift_s;
  assign off_full_s   = acc_mid_r >>> shift_s;
  assign flush_s      = (state_r == ST_FLUSH);

  // Result fields fit HW bits exactly because the mean of halves stays in range
  always_comb begin
    result_s           = '0;
    result_s.offset    = off_full_s[HW-1:0];
    result_s.amplitude = amp_full_s[HW-1:0];
  end

  // Frame FSM: a pair seen in ST_FLUSH opens the next frame in the same cycle
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r   <= ST_IDLE;
      lc_r      <= 5'd0;
      count_r   <= '0;
      acc_pp_r  <= '0;
      acc_mid_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FLUSH: begin
          if (s1_valid_r) begin
            lc_r      <= s1_lc_r;
            count_r   <= '0;
            acc_pp_r  <= ACC_W'(s1_pp_r);
            acc_mid_r <= ACC_W'(s1_mid_r);
            state_r   <= (s1_lc_r == 5'd0) ? ST_FLUSH : ST_ACCUM;
          end else begin
            count_r   <= '0;
            acc_pp_r  <= '0;
            acc_mid_r <= '0;
            state_r   <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (s1_valid_r) begin
            acc_pp_r  <= acc_pp_r + ACC_W'(s1_pp_r);
            acc_mid_r <= acc_mid_r + ACC_W'(s1_mid_r);
            count_r   <= count_next_s;
            if (count_next_s == last_idx_s) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  axis_result_holder u_holder (
    .clk       (aclk),
    .rst       (areset),
    .load      (flush_s),
    .load_data (result_s),
    .ready     (M_AXIS_tready),
    .data      (hold_data_s),
    .valid     (M_AXIS_tvalid),
    .overrun   (overrun)
  );

  assign M_AXIS_tdata = hold_data_s;

`ifdef AXIS_EXTREMUM_PEAK_HOLD_EN
  logic [HW-1:0] peak_r;

  // Peak tracker: a result loaded alongside a clear still registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      peak_r <= '0;
    end else if (flush_s) begin
      if (clear_peak || (result_s.amplitude > peak_r)) begin
        peak_r <= result_s.amplitude;
      end
    end else if (clear_peak) begin
      peak_r <= '0;
    end
  end

  assign peak_amplitude = peak_r;
`endif

endmodule

// File: tb/tb_axis_extremum_averager.sv
// Directed and randomized bench for axis_extremum_averager against an
// arithmetic reference model of the frame averages.
module tb_axis_extremum_averager;

  logic        aclk = 1'b0;
  logic        areset;
  logic [4:0]  log_count;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic        overrun;
`ifdef AXIS_EXTREMUM_PEAK_HOLD_EN
  logic        clear_peak;
  logic [15:0] peak_amplitude;
`endif

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int overruns = 0;
  int pmax[$];
  int pmin[$];

  axis_extremum_averager dut (
    .aclk          (aclk),
    .areset        (areset),
    .log_count     (log_count),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .overrun       (overrun)
`ifdef AXIS_EXTREMUM_PEAK_HOLD_EN
    ,
    .clear_peak    (clear_peak),
    .peak_amplitude(peak_amplitude)
`endif
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (M_AXIS_tvalid && M_AXIS_tready) beats <= beats + 1;
    if (overrun) overruns <= overruns + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Mean of midpoints and half-ranges over the queued frame
  function automatic logic [31:0] model(input int lc);
    longint smid, spp, d, off, amp;
    int l;
    smid = 0;
    spp = 0;
    l = (lc > 16) ? 16 : lc;
    foreach (pmax[i]) begin
      smid += pmax[i] + pmin[i];
      if (pmax[i] > pmin[i]) spp += pmax[i] - pmin[i];
    end
    d = longint'(1) << (l + 1);
    off = floor_div(smid, d);
    amp = spp / d;
    return {off[15:0], amp[15:0]};
  endfunction

  function automatic int rand16();
    logic signed [15:0] t;
    int r;
    r = $urandom_range(0, 7);
    t = 16'($urandom);
    if (r == 0) return 32767;
    else if (r == 1) return -32768;
    else return int'(t);
  endfunction

  task automatic new_frame;
    pmax.delete();
    pmin.delete();
  endtask

  task automatic add_pair(input int mx, input int mn);
    pmax.push_back(mx);
    pmin.push_back(mn);
  endtask

  task automatic send_frame(input int lc, input int lc_after, input bit gaps);
    foreach (pmax[i]) begin
      log_count = (i == 0) ? 5'(lc) : 5'(lc_after);
      S_AXIS_tdata = {16'(pmax[i]), 16'(pmin[i])};
      S_AXIS_tvalid = 1'b1;
      tick;
      S_AXIS_tvalid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick;
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!M_AXIS_tvalid && n < 40) begin
      tick;
      n++;
    end
    check({tag, "_valid"}, 32'(M_AXIS_tvalid), 32'd1);
    check(tag, M_AXIS_tdata, exp);
    M_AXIS_tready = 1'b1;
    tick;
    M_AXIS_tready = 1'b0;
    check({tag, "_drained"}, 32'(M_AXIS_tvalid), 32'd0);
  endtask

  initial begin
    int b0, o0, lc;
    areset = 1'b1;
    log_count = 5'd0;
    S_AXIS_tdata = 32'd0;
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b0;
`ifdef AXIS_EXTREMUM_PEAK_HOLD_EN
    clear_peak = 1'b0;
`endif
    repeat (3) tick;
    check("rst_s_tready", 32'(S_AXIS_tready), 32'd0);
    check("rst_m_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    check("rst_m_tdata", M_AXIS_tdata, 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    areset = 1'b0;
    tick;
    check("s_tready_up", 32'(S_AXIS_tready), 32'd1);

    // lc=0 pass-through with exact latency and hold
    new_frame();
    add_pair(20, -20);
    b0 = beats;
    send_frame(0, 0, 1'b0);
    check("lat_n0", 32'(M_AXIS_tvalid), 32'd0);
    tick;
    check("lat_n1", 32'(M_AXIS_tvalid), 32'd0);
    tick;
    check("lat_n2", 32'(M_AXIS_tvalid), 32'd1);
    check("lc0_data", M_AXIS_tdata, {16'd0, 16'd20});
    repeat (3) tick;
    check("lc0_hold_valid", 32'(M_AXIS_tvalid), 32'd1);
    check("lc0_hold_data", M_AXIS_tdata, {16'd0, 16'd20});
    M_AXIS_tready = 1'b1;
    tick;
    M_AXIS_tready = 1'b0;
    check("lc0_beats", 32'(beats), 32'(b0 + 1));
    check("lc0_drained", 32'(M_AXIS_tvalid), 32'd0);

    // lc=2 four-pair frame, exactly one beat
    new_frame();
    add_pair(40, -40); add_pair(60, -20); add_pair(20, -20); add_pair(40, 0);
    b0 = beats;
    send_frame(2, 2, 1'b0);
    expect_result("lc2", {16'd10, 16'd30});
    repeat (5) tick;
    check("lc2_one_beat", 32'(beats), 32'(b0 + 1));

    // inverted pair
    new_frame();
    add_pair(10, 20);
    send_frame(0, 0, 1'b0);
    expect_result("inverted", {16'd15, 16'd0});

    // overwrite of an unaccepted result
    o0 = overruns;
    b0 = beats;
    new_frame();
    add_pair(20, -20);
    send_frame(0, 0, 1'b0);
    repeat (3) tick;
    new_frame();
    add_pair(30, -10);
    send_frame(0, 0, 1'b0);
    repeat (3) tick;
    check("ovr_count", 32'(overruns), 32'(o0 + 1));
    check("ovr_data", M_AXIS_tdata, {16'd10, 16'd20});
    M_AXIS_tready = 1'b1;
    tick;
    M_AXIS_tready = 1'b0;
    repeat (3) tick;
    check("ovr_one_beat", 32'(beats), 32'(b0 + 1));
    check("ovr_drained", 32'(M_AXIS_tvalid), 32'd0);

    // back-to-back results with continuous accept: no overrun
    M_AXIS_tready = 1'b1;
    o0 = overruns;
    b0 = beats;
    new_frame();
    add_pair(1, -1); add_pair(2, -2); add_pair(3, -3);
    send_frame(0, 0, 1'b0);
    repeat (6) tick;
    M_AXIS_tready = 1'b0;
    check("b2b_beats", 32'(beats), 32'(b0 + 3));
    check("b2b_no_ovr", 32'(overruns), 32'(o0));
    check("b2b_last", M_AXIS_tdata, {16'd0, 16'd3});

    // asynchronous reset mid-frame with a pending result
    new_frame();
    add_pair(20, -20);
    send_frame(0, 0, 1'b0);
    repeat (3) tick;
    check("pre_rst_valid", 32'(M_AXIS_tvalid), 32'd1);
    new_frame();
    add_pair(40, -40); add_pair(60, -20);
    send_frame(2, 2, 1'b0);
    areset = 1'b1;
    #1;
    check("async_rst_valid", 32'(M_AXIS_tvalid), 32'd0);
    check("async_rst_tready", 32'(S_AXIS_tready), 32'd0);
    tick;
    areset = 1'b0;
    tick;
    new_frame();
    add_pair(40, -40); add_pair(60, -20); add_pair(20, -20); add_pair(40, 0);
    send_frame(2, 2, 1'b0);
    expect_result("post_rst", {16'd10, 16'd30});

    // log_count change inside a frame is ignored
    new_frame();
    add_pair(40, -40); add_pair(60, -20); add_pair(20, -20); add_pair(40, 0);
    send_frame(2, 0, 1'b0);
    expect_result("lc_change", {16'd10, 16'd30});

    // full-scale extremes over 16 pairs
    new_frame();
    for (int i = 0; i < 16; i++) add_pair(32767, -32768);
    send_frame(4, 4, 1'b0);
    expect_result("full_scale", {16'hFFFF, 16'd32767});

    // randomized frames against the model
    for (int f = 0; f < 12; f++) begin
      lc = $urandom_range(0, 3);
      new_frame();
      for (int i = 0; i < (1 << lc); i++) add_pair(rand16(), rand16());
      send_frame(lc, lc, f[0]);
      expect_result($sformatf("rand%0d", f), model(lc));
    end

`ifdef AXIS_EXTREMUM_PEAK_HOLD_EN
    new_frame();
    add_pair(30, -30);
    send_frame(0, 0, 1'b0);
    expect_result("peak_a", {16'd0, 16'd30});
    new_frame();
    add_pair(10, -10);
    send_frame(0, 0, 1'b0);
    expect_result("peak_b", {16'd0, 16'd10});
    check("peak_hold", 32'(peak_amplitude), 32'd30);
    clear_peak = 1'b1;
    tick;
    clear_peak = 1'b0;
    check("peak_clear", 32'(peak_amplitude), 32'd0);
    new_frame();
    add_pair(10, -10);
    send_frame(0, 0, 1'b0);
    expect_result("peak_c", {16'd0, 16'd10});
    check("peak_after_clear", 32'(peak_amplitude), 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
